// File: rtl/inport_feeder.sv
// Device-side producer for the CPU input port: a small FIFO feeding Input_port_register one word at a time.
// Optional status ports (fifo_level, overrun, clr_overrun) are built when INPORT_STATUS_EN is defined.
module inport_feeder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dev_data,
    input  logic             dev_valid,
    output logic             dev_ready,
    input  logic             cpu_read,
    output logic [WIDTH-1:0] device_data,
    output logic             inport_strobe,
    output logic             port_valid
`ifdef INPORT_STATUS_EN
    ,
    output logic [AW:0]      fifo_level,
    output logic             overrun,
    input  logic             clr_overrun
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] device_data_nxt;
    logic             strobe_nxt;
    logic             port_valid_nxt;
    logic             push;
    logic             pop;

    // Full blocks a push even when a pop happens on the same edge.
    assign dev_ready = (count != FULL_COUNT);
    assign push      = dev_valid & dev_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= dev_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            device_data   <= '0;
            inport_strobe <= 1'b0;
            port_valid    <= 1'b0;
        end else begin
            state         <= state_nxt;
            device_data   <= device_data_nxt;
            inport_strobe <= strobe_nxt;
            port_valid    <= port_valid_nxt;
        end
    end

    // The presented word stays at the FIFO head until the HOLD-state read pops it.
    always_comb begin
        state_nxt       = state;
        device_data_nxt = device_data;
        strobe_nxt      = 1'b0;
        port_valid_nxt  = port_valid;
        pop             = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt       = LOAD;
                    device_data_nxt = mem[rd_ptr];
                    strobe_nxt      = 1'b1;
                end
            end
            LOAD: begin
                port_valid_nxt = 1'b1;
                state_nxt      = HOLD;
            end
            HOLD: begin
                if (cpu_read) begin
                    pop            = 1'b1;
                    port_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef INPORT_STATUS_EN
    assign fifo_level = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (dev_valid && !dev_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_inport_feeder.sv
// Scoreboard bench for inport_feeder: a queue-and-timestamp reference model predicts strobes and status.
// Status checks compile in when INPORT_STATUS_EN is defined.
module tb_inport_feeder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] dev_data = '0;
    logic             dev_valid = 1'b0;
    logic             dev_ready;
    logic             cpu_read = 1'b0;
    logic [WIDTH-1:0] device_data;
    logic             inport_strobe;
    logic             port_valid;
`ifdef INPORT_STATUS_EN
    logic [AW:0]      fifo_level;
    logic             overrun;
    logic             clr_overrun = 1'b0;
`endif

    inport_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .dev_data      (dev_data),
        .dev_valid     (dev_valid),
        .dev_ready     (dev_ready),
        .cpu_read      (cpu_read),
        .device_data   (device_data),
        .inport_strobe (inport_strobe),
        .port_valid    (port_valid)
`ifdef INPORT_STATUS_EN
        ,
        .fifo_level    (fifo_level),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: words in the buffer (presented word included) plus the edge at which it was strobed.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] sb[$];
    bit               m_occ = 1'b0;
    int               m_occ_edge = 0;
    int               m_edge = 0;
    logic [WIDTH-1:0] m_dd = '0;
    bit               m_strobe = 1'b0;
    bit               m_ovr = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        m_q.delete();
        sb.delete();
        m_occ    = 1'b0;
        m_dd     = '0;
        m_strobe = 1'b0;
        m_ovr    = 1'b0;
    endtask

    always @(posedge clock) begin
        bit ready;
        bit acc;
        bit pop;
        bit strb;
        if (reset) begin
            m_edge++;
            ready = (m_q.size() != DEPTH);
            acc   = dev_valid && ready;
            pop   = m_occ && (m_edge >= m_occ_edge + 2) && cpu_read;
            strb  = !m_occ && (m_q.size() != 0);
`ifdef INPORT_STATUS_EN
            if (dev_valid && !ready) m_ovr = 1'b1;
            else if (clr_overrun) m_ovr = 1'b0;
`endif
            m_strobe = strb;
            if (strb) begin
                m_dd = m_q[0];
                sb.push_back(m_q[0]);
                m_occ = 1'b1;
                m_occ_edge = m_edge;
            end
            if (pop) begin
                void'(m_q.pop_front());
                m_occ = 1'b0;
            end
            if (acc) m_q.push_back(dev_data);
        end
    end

    // Monitor: every strobe must consume the oldest expected word.
    always @(negedge clock) begin
        logic [WIDTH-1:0] exp_word;
        if (reset) begin
            check1("dev_ready", dev_ready, m_q.size() != DEPTH);
            check1("port_valid", port_valid, m_occ && (m_edge >= m_occ_edge + 1));
            check1("inport_strobe", inport_strobe, m_strobe);
            checkw("device_data", device_data, m_dd);
            if (inport_strobe) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=%08h expected=none at %0t", device_data, $time);
                end else begin
                    exp_word = sb.pop_front();
                    checkw("strobe_word", device_data, exp_word);
                end
            end
`ifdef INPORT_STATUS_EN
            checkw("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            check1("overrun", overrun, m_ovr);
`endif
        end
    end

    task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit r);
        @(negedge clock);
        dev_valid = v;
        dev_data  = d;
        cpu_read  = r;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!(m_occ && (m_edge >= m_occ_edge + 1)) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!(m_occ && (m_edge >= m_occ_edge + 1))) begin
            checks++;
            failures++;
            $display("FAIL %s actual=timeout expected=word_presented at %0t", name, $time);
        end
    endtask

    task automatic pop_one(input string name);
        wait_valid(name);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        dev_valid = 1'b0;
        while ((m_q.size() != 0 || m_occ) && n < 200) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        cyc(1'b0, '0, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0);
        checkw(name, 32'(sb.size()), 32'd0);
        check1({name, "_ready"}, dev_ready, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check1("rst_dev_ready", dev_ready, 1'b1);
        check1("rst_port_valid", port_valid, 1'b0);
        check1("rst_strobe", inport_strobe, 1'b0);
        checkw("rst_device_data", device_data, 32'h0);
        reset = 1'b1;
        repeat (2) cyc(1'b0, '0, 1'b0);

        // Single word latency
        cyc(1'b1, 32'h0000_00C0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        pop_one("single_word");
        repeat (3) cyc(1'b0, '0, 1'b0);

        // Fill to full, then offer a fifth word that must be refused
        cyc(1'b1, 32'h11, 1'b0);
        cyc(1'b1, 32'h22, 1'b0);
        cyc(1'b1, 32'h33, 1'b0);
        cyc(1'b1, 32'h44, 1'b0);
        cyc(1'b1, 32'h55, 1'b0);
        cyc(1'b1, 32'h55, 1'b0);
        cyc(1'b0, '0, 1'b0);
        check1("full_not_ready", dev_ready, 1'b0);
`ifdef INPORT_STATUS_EN
        check1("overrun_set", overrun, 1'b1);
        @(negedge clock);
        clr_overrun = 1'b1;
        @(negedge clock);
        clr_overrun = 1'b0;
`endif

        // Drain in order with single-cycle reads
        for (int i = 0; i < 4; i++) pop_one("drain_order");
        repeat (3) cyc(1'b0, '0, 1'b0);
        check1("empty_after_drain", dev_ready, 1'b1);

        // Long read pulse pops only the presented word
        cyc(1'b1, 32'hA5A5_0001, 1'b0);
        cyc(1'b0, '0, 1'b0);
        wait_valid("held_read");
        repeat (5) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 32'hA5A5_0002, 1'b0);
        cyc(1'b0, '0, 1'b0);
        pop_one("after_held_read");

        // Simultaneous push and pop with two words buffered
        cyc(1'b1, 32'hB1, 1'b0);
        cyc(1'b1, 32'hB2, 1'b0);
        cyc(1'b0, '0, 1'b0);
        wait_valid("push_pop");
        cyc(1'b1, 32'hB3, 1'b1);
        cyc(1'b0, '0, 1'b0);
`ifdef INPORT_STATUS_EN
        checkw("push_pop_level", 32'(fifo_level), 32'd2);
`endif
        drain("push_pop_drain");

        // Asynchronous reset while holding with three words queued
        cyc(1'b1, 32'hD1, 1'b0);
        cyc(1'b1, 32'hD2, 1'b0);
        cyc(1'b1, 32'hD3, 1'b0);
        cyc(1'b0, '0, 1'b0);
        wait_valid("reset_hold");
        @(negedge clock);
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        check1("midrst_port_valid", port_valid, 1'b0);
        check1("midrst_dev_ready", dev_ready, 1'b1);
        check1("midrst_strobe", inport_strobe, 1'b0);
        checkw("midrst_device_data", device_data, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) cyc(1'b0, '0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 3));
`ifdef INPORT_STATUS_EN
            clr_overrun = ($urandom_range(0, 9) == 0);
`endif
        end
`ifdef INPORT_STATUS_EN
        clr_overrun = 1'b0;
`endif
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
